// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  typedef enum logic {OWN_FETCH, OWN_DATA} owner_t;

  localparam logic [3:0] SEL_ALL = 4'hF;

endpackage

// File: rtl/mem_arb_grant.sv
// rtl/mem_arb_grant.sv - data-priority grant decision with fetch starvation limit
module mem_arb_grant
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   req_if,
  input  logic   req_d,
  input  logic   idle,
  output owner_t grant
);

  localparam int            CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  logic          starved;

  // Data wins a tie until fetch has been passed over LIMIT times in a row;
  // the counter only moves on IDLE cycles, which are the only grant cycles.
  always_comb begin
    starved      = (starve_cnt_q == LIMIT);
    grant        = (req_d && !(req_if && starved)) ? OWN_DATA : OWN_FETCH;
    starve_cnt_d = starve_cnt_q;
    if (idle) begin
      if (!req_if || grant == OWN_FETCH) begin
        starve_cnt_d = '0;
      end else if (!starved) begin
        starve_cnt_d = starve_cnt_q + CW'(1);
      end
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares the memory Wishbone port between fetch and data requesters
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 10,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic                  if_stb,
  output logic                  if_stall,
  output logic                  if_ack,
  output logic [31:0]           if_instr,
  input  logic                  d_cyc,
  input  logic                  d_stb,
  input  logic                  d_wr_en,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [31:0]           d_wr_data,
  input  logic [3:0]            d_sel,
  output logic                  d_stall,
  output logic                  d_ack,
  output logic [31:0]           d_rd_data,
  output logic                  m_cyc,
  output logic                  m_stb,
  output logic                  m_wr_en,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [31:0]           m_wr_data,
  output logic [3:0]            m_sel,
  input  logic                  m_ack,
  input  logic                  m_stall,
  input  logic [31:0]           m_rd_data,
  output logic                  bus_err
);

  localparam int            TW    = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  state_t                  state_q, state_d;
  owner_t                  owner_q, owner_d;
  logic [ADDR_WIDTH-1:0]   m_addr_q, m_addr_d;
  logic                    m_wr_en_q, m_wr_en_d;
  logic [31:0]             m_wr_data_q, m_wr_data_d;
  logic [3:0]              m_sel_q, m_sel_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic                    abort_q, abort_d;
  logic                    if_ack_q, if_ack_d;
  logic                    d_ack_q, d_ack_d;
  logic [31:0]             if_instr_q, if_instr_d;
  logic [31:0]             d_rd_data_q, d_rd_data_d;
  logic                    bus_err_q, bus_err_d;

  owner_t                  grant;
  logic                    idle, req_d, accept_if, accept_d, aborting;
  logic                    deliver;
  logic [31:0]             resp;

  assign idle      = (state_q == IDLE);
  assign req_d     = d_cyc & d_stb;
  assign accept_if = rst_n & idle & if_stb & (grant == OWN_FETCH);
  assign accept_d  = rst_n & idle & req_d & (grant == OWN_DATA);
  assign if_stall  = !accept_if;
  assign d_stall   = !accept_d;

  // Once the data master lets go of its cycle the transaction is orphaned for good.
  assign aborting  = (owner_q == OWN_DATA) && (abort_q || !d_cyc);

  assign m_wr_en   = m_wr_en_q;
  assign m_addr    = m_addr_q;
  assign m_wr_data = m_wr_data_q;
  assign m_sel     = m_sel_q;
  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign if_instr  = if_instr_q;
  assign d_rd_data = d_rd_data_q;
  assign bus_err   = bus_err_q;

  mem_arb_grant #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_grant (
    .clk   (clk),
    .rst_n (rst_n),
    .req_if(if_stb),
    .req_d (req_d),
    .idle  (idle),
    .grant (grant)
  );

  // Transaction FSM: latch on accept, drive the bus, then return a response or time out.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    m_addr_d    = m_addr_q;
    m_wr_en_d   = m_wr_en_q;
    m_wr_data_d = m_wr_data_q;
    m_sel_d     = m_sel_q;
    timer_d     = timer_q;
    abort_d     = abort_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    if_instr_d  = if_instr_q;
    d_rd_data_d = d_rd_data_q;
    bus_err_d   = bus_err_q;
    m_cyc       = 1'b0;
    m_stb       = 1'b0;
    deliver     = 1'b0;
    resp        = '0;
    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        timer_d = '0;
        if (accept_d) begin
          owner_d     = OWN_DATA;
          m_addr_d    = d_addr;
          m_wr_en_d   = d_wr_en;
          m_wr_data_d = d_wr_data;
          m_sel_d     = d_sel;
          state_d     = REQ;
        end else if (accept_if) begin
          owner_d     = OWN_FETCH;
          m_addr_d    = if_addr;
          m_wr_en_d   = 1'b0;
          m_wr_data_d = '0;
          m_sel_d     = SEL_ALL;
          state_d     = REQ;
        end
      end
      REQ: begin
        m_cyc   = 1'b1;
        m_stb   = !aborting;
        timer_d = '0;
        if (aborting) begin
          abort_d = 1'b1;
          state_d = WAIT;
        end else if (!m_stall) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        m_cyc   = 1'b1;
        timer_d = timer_q + TW'(1);
        if (aborting) begin
          abort_d = 1'b1;
        end
        if (m_ack) begin
          state_d = IDLE;
          deliver = !aborting;
          resp    = m_rd_data;
        end else if (timer_q == TLAST) begin
          state_d = IDLE;
          deliver = !aborting;
          if (!aborting) begin
            bus_err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (deliver) begin
      if (owner_q == OWN_FETCH) begin
        if_ack_d   = 1'b1;
        if_instr_d = resp;
      end else begin
        d_ack_d     = 1'b1;
        d_rd_data_d = resp;
      end
    end
  end

  // State and transaction registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_FETCH;
      m_addr_q    <= '0;
      m_wr_en_q   <= 1'b0;
      m_wr_data_q <= '0;
      m_sel_q     <= '0;
      timer_q     <= '0;
      abort_q     <= 1'b0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_instr_q  <= '0;
      d_rd_data_q <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      m_addr_q    <= m_addr_d;
      m_wr_en_q   <= m_wr_en_d;
      m_wr_data_q <= m_wr_data_d;
      m_sel_q     <= m_sel_d;
      timer_q     <= timer_d;
      abort_q     <= abort_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      if_instr_q  <= if_instr_d;
      d_rd_data_q <= d_rd_data_d;
      bus_err_q   <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic [9:0]  if_addr;
  logic        if_stb, if_stall, if_ack;
  logic [31:0] if_instr;
  logic        d_cyc, d_stb, d_wr_en, d_stall, d_ack;
  logic [9:0]  d_addr;
  logic [31:0] d_wr_data, d_rd_data;
  logic [3:0]  d_sel;
  logic        m_cyc, m_stb, m_wr_en, m_ack, m_stall;
  logic [9:0]  m_addr;
  logic [31:0] m_wr_data, m_rd_data;
  logic [3:0]  m_sel;
  logic        bus_err;

  logic        mem_clr, ack_en, inj_ack, mem_ack;
  logic [31:0] mem_rd;
  logic [31:0] mem [0:255];

  int n_vec;
  int n_err;

  mem_port_arbiter #(
    .ADDR_WIDTH  (10),
    .STARVE_LIMIT(4),
    .TIMEOUT     (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_addr  (if_addr),
    .if_stb   (if_stb),
    .if_stall (if_stall),
    .if_ack   (if_ack),
    .if_instr (if_instr),
    .d_cyc    (d_cyc),
    .d_stb    (d_stb),
    .d_wr_en  (d_wr_en),
    .d_addr   (d_addr),
    .d_wr_data(d_wr_data),
    .d_sel    (d_sel),
    .d_stall  (d_stall),
    .d_ack    (d_ack),
    .d_rd_data(d_rd_data),
    .m_cyc    (m_cyc),
    .m_stb    (m_stb),
    .m_wr_en  (m_wr_en),
    .m_addr   (m_addr),
    .m_wr_data(m_wr_data),
    .m_sel    (m_sel),
    .m_ack    (m_ack),
    .m_stall  (m_stall),
    .m_rd_data(m_rd_data),
    .bus_err  (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle memory: accepts a strobe when not stalled, acks on the next cycle.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      mem[4]  <= 32'h00500093;
      mem[9]  <= 32'h11223344;
      mem_ack <= 1'b0;
      mem_rd  <= '0;
    end else begin
      mem_ack <= 1'b0;
      if (m_cyc && m_stb && !m_stall) begin
        for (int b = 0; b < 4; b++)
          if (m_wr_en && m_sel[b]) mem[m_addr[9:2]][8*b +: 8] <= m_wr_data[8*b +: 8];
        mem_rd  <= mem[m_addr[9:2]];
        mem_ack <= ack_en;
      end
    end
  end

  assign m_ack     = mem_ack | inj_ack;
  assign m_rd_data = mem_rd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic data_rd(input logic [9:0] a, output logic [31:0] rd);
    int n;
    @(negedge clk);
    d_cyc = 1'b1; d_stb = 1'b1; d_wr_en = 1'b0; d_addr = a; d_sel = 4'hF;
    #1;
    n = 0;
    while (d_stall && n < 40) begin @(negedge clk); #1; n++; end
    @(negedge clk);
    d_stb = 1'b0;
    #1;
    n = 0;
    while (!d_ack && n < 40) begin @(negedge clk); #1; n++; end
    chk("rd_ack_seen", d_ack, 1);
    rd = d_rd_data;
    @(negedge clk);
    d_cyc = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [9:0]  seq;
    int          ng, last_fa, gap, n_fa;

    n_vec = 0; n_err = 0;
    rst_n = 1'b0; mem_clr = 1'b1; ack_en = 1'b1; inj_ack = 1'b0; m_stall = 1'b0;
    if_stb = 1'b1; if_addr = '0;
    d_cyc = 1'b1; d_stb = 1'b1; d_wr_en = 1'b0; d_addr = '0; d_wr_data = '0; d_sel = '0;

    // Reset state, with both requesters asserting during reset.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_if_stall", if_stall, 1);
    chk("rst_d_stall", d_stall, 1);
    chk("rst_m_cyc", m_cyc, 0);
    chk("rst_m_stb", m_stb, 0);
    chk("rst_acks", {if_ack, d_ack}, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_if_instr", if_instr, 0);
    chk("rst_d_rd_data", d_rd_data, 0);
    @(negedge clk);
    if_stb = 1'b0; d_cyc = 1'b0; d_stb = 1'b0; mem_clr = 1'b0; rst_n = 1'b1;

    // Fetch only.
    @(negedge clk); if_stb = 1'b1; if_addr = 10'h010; #1;
    chk("f_stall_n", if_stall, 0);
    chk("f_d_stall_idle", d_stall, 1);
    @(negedge clk); if_stb = 1'b0; #1;
    chk("f_m_stb", {m_cyc, m_stb}, 2'b11);
    chk("f_m_addr", m_addr, 10'h010);
    chk("f_m_wr_sel", {m_wr_en, m_sel}, 5'b01111);
    @(negedge clk); #1;
    chk("f_ack_n2", if_ack, 0);
    @(negedge clk); #1;
    chk("f_ack_n3", if_ack, 1);
    chk("f_instr", if_instr, 32'h00500093);
    chk("f_no_d_ack", d_ack, 0);
    @(negedge clk); #1;
    chk("f_ack_pulse", if_ack, 0);
    chk("f_instr_held", if_instr, 32'h00500093);

    // Data write of the low half-word.
    @(negedge clk);
    d_cyc = 1'b1; d_stb = 1'b1; d_wr_en = 1'b1; d_addr = 10'h024;
    d_wr_data = 32'hDEADBEEF; d_sel = 4'b0011;
    #1;
    chk("w_d_stall_n", d_stall, 0);
    @(negedge clk); d_stb = 1'b0; #1;
    chk("w_m_wr_sel", {m_wr_en, m_sel}, 5'b10011);
    chk("w_m_data", m_wr_data, 32'hDEADBEEF);
    chk("w_m_addr", m_addr, 10'h024);
    @(negedge clk); #1;
    chk("w_ack_n2", d_ack, 0);
    @(negedge clk); #1;
    chk("w_ack_n3", d_ack, 1);
    @(negedge clk); d_cyc = 1'b0; d_wr_en = 1'b0;
    data_rd(10'h024, rd);
    chk("w_readback_lo", rd[15:0], 16'hBEEF);
    chk("w_readback", rd, 32'h1122BEEF);

    // Starvation: both request continuously until ten grants are seen.
    seq = '0; ng = 0; last_fa = -1; gap = 0; n_fa = 0;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if_stb = (ng < 10); d_cyc = (ng < 10); d_stb = (ng < 10);
      if_addr = 10'h010; d_addr = 10'h024; d_wr_en = 1'b0; d_sel = 4'hF;
      #1;
      if (if_ack) begin
        if (last_fa >= 0) gap = c - last_fa;
        last_fa = c;
        n_fa++;
      end
      if (ng < 10 && !d_stall) begin seq[9-ng] = 1'b1; ng++; end
      else if (ng < 10 && !if_stall) begin seq[9-ng] = 1'b0; ng++; end
    end
    chk("starve_grants", ng, 10);
    chk("starve_seq", seq, 10'b1111011110);
    chk("starve_fetch_acks", n_fa, 2);
    chk("starve_fetch_gap", gap, 15);

    // Memory stall for three cycles in REQ while fetch waits.
    @(negedge clk); d_cyc = 1'b1; d_stb = 1'b1; d_addr = 10'h010; #1;
    chk("st_accept", d_stall, 0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      d_stb = 1'b0; if_stb = 1'b1; if_addr = 10'h024; m_stall = (k < 4);
      #1;
      chk("st_m_stb_high", m_stb, 1);
      chk("st_if_stall_held", if_stall, 1);
    end
    @(negedge clk); #1;
    chk("st_m_stb_low", m_stb, 0);
    chk("st_no_early_ack", d_ack, 0);
    chk("st_if_stall_n5", if_stall, 1);
    @(negedge clk); #1;
    chk("st_d_ack", d_ack, 1);
    chk("st_d_rd", d_rd_data, 32'h00500093);
    chk("st_fetch_accept", if_stall, 0);
    @(negedge clk); d_cyc = 1'b0; if_stb = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    chk("st_if_ack", if_ack, 1);
    chk("st_if_instr", if_instr, 32'h1122BEEF);

    // Timeout with a silent memory.
    ack_en = 1'b0;
    @(negedge clk); if_stb = 1'b1; if_addr = 10'h000; #1;
    chk("to_accept", if_stall, 0);
    @(negedge clk); if_stb = 1'b0;
    repeat (16) @(negedge clk);
    #1;
    chk("to_no_ack_early", if_ack, 0);
    chk("to_no_err_early", bus_err, 0);
    @(negedge clk); #1;
    chk("to_ack", if_ack, 1);
    chk("to_instr_zero", if_instr, 0);
    chk("to_bus_err", bus_err, 1);
    ack_en = 1'b1;
    data_rd(10'h010, rd);
    chk("to_after_rd", rd, 32'h00500093);
    chk("to_err_sticky", bus_err, 1);

    // Reset while in WAIT, then a stray ack.
    ack_en = 1'b0;
    @(negedge clk); if_stb = 1'b1; if_addr = 10'h010;
    @(negedge clk); if_stb = 1'b0;
    @(negedge clk); rst_n = 1'b0; #1;
    chk("rw_in_wait", m_cyc, 1);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("rw_m_cyc", m_cyc, 0);
    chk("rw_no_ack", {if_ack, d_ack}, 0);
    chk("rw_err_clear", bus_err, 0);
    chk("rw_instr_clear", if_instr, 0);
    @(negedge clk); inj_ack = 1'b1;
    @(negedge clk); inj_ack = 1'b0; #1;
    chk("rw_stray_ack", {if_ack, d_ack, m_cyc}, 0);
    @(negedge clk); #1;
    chk("rw_stray_ack2", {if_ack, d_ack}, 0);

    // Data abort in WAIT.
    @(negedge clk);
    d_cyc = 1'b1; d_stb = 1'b1; d_wr_en = 1'b1; d_addr = 10'h030;
    d_wr_data = 32'hCAFE0000; d_sel = 4'hF;
    #1;
    chk("ab_accept", d_stall, 0);
    @(negedge clk); d_stb = 1'b0; #1;
    chk("ab_req_stb", m_stb, 1);
    @(negedge clk); d_cyc = 1'b0; d_wr_en = 1'b0; #1;
    chk("ab_stb_drop", {m_cyc, m_stb}, 2'b10);
    @(negedge clk); #1;
    chk("ab_cyc_held", m_cyc, 1);
    chk("ab_no_ack", d_ack, 0);
    @(negedge clk); inj_ack = 1'b1;
    @(negedge clk); inj_ack = 1'b0; ack_en = 1'b1; #1;
    chk("ab_idle", m_cyc, 0);
    chk("ab_ack_suppressed", d_ack, 0);
    chk("ab_no_err", bus_err, 0);
    data_rd(10'h030, rd);
    chk("ab_write_committed", rd, 32'hCAFE0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported main memory Wishbone data port between two requesters: the stage-1 fetch port (stb/ack) and the stage-4 data Wishbone port.
- The fetch port is converted into a read-only Wishbone master transaction.
- Arbitration is data-priority, with a starvation limit that guarantees fetch progress.
- A bus timeout turns a lost ack into a completed transaction plus a sticky error flag.

Parameters:
- ADDR_WIDTH, 10, byte-address width of every port (matches the memory's $clog2(MEMORY_BYTES)).
- STARVE_LIMIT, 4, max consecutive data grants while fetch is pending before fetch is forced; legal range >= 1.
- TIMEOUT, 16, cycles spent in WAIT without m_ack before forced completion; legal range >= 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- if_addr  in  ADDR_WIDTH  fetch byte address
- if_stb  in  1  fetch request, held until accepted
- if_stall  out  1  fetch request not accepted this cycle
- if_ack  out  1  one-cycle fetch completion pulse
- if_instr  out  32  fetched word, valid with if_ack, held afterwards
- d_cyc, d_stb, d_wr_en  in  1 each  data Wishbone cycle, strobe and write enable
- d_addr  in  ADDR_WIDTH  data byte address
- d_wr_data  in  32  data write data
- d_sel  in  4  data byte-lane select
- d_stall  out  1  data request not accepted this cycle
- d_ack  out  1  one-cycle data completion pulse
- d_rd_data  out  32  data read word, valid with d_ack, held afterwards
- m_cyc, m_stb, m_wr_en  out  1 each  Wishbone master to memory
- m_addr  out  ADDR_WIDTH  memory address
- m_wr_data  out  32  memory write data
- m_sel  out  4  memory byte-lane select
- m_ack  in  1  memory ack
- m_stall  in  1  memory stall
- m_rd_data  in  32  memory read data
- bus_err  out  1  sticky: a timeout has occurred

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, starve_cnt=0, timer=0.
  - m_cyc, m_stb, if_ack, d_ack, bus_err = 0; if_instr = d_rd_data = 0.
  - if_stall = d_stall = 1 while rst_n=0.
- Requests:
  - Fetch request = if_stb. Data request = d_cyc & d_stb.
  - A request is accepted in the cycle its stall is low.
  - Stalls are combinational: a requester's stall = !(state==IDLE & grant==that requester). A non-requesting port sees stall=1.
- Grant (computed in IDLE only):
  - Only one requester pending -> it wins.
  - Both pending -> data wins, unless starve_cnt==STARVE_LIMIT, in which case fetch wins.
  - starve_cnt increments on a data grant while if_stb=1, saturating at STARVE_LIMIT. It clears on a fetch grant and on any IDLE cycle with if_stb=0.
- On accept:
  - Latch owner, address, wr_en, wr_data and sel into the m_* registers.
  - A fetch is latched as wr_en=0, sel=4'hF.
  - Go to REQ.
- REQ state:
  - m_cyc=1, m_stb=1.
  - If m_stall=0 -> WAIT with timer=0; otherwise remain in REQ.
- WAIT state:
  - m_cyc=1, m_stb=0; timer increments each cycle.
  - On m_ack: capture m_rd_data into the owner's read register, pulse the owner's ack next cycle, go to IDLE.
  - If timer reaches TIMEOUT-1 with no ack: go to IDLE, pulse the owner's ack with read data 0, set bus_err.
- Latency with a 1-cycle memory:
  - accept at N, m_stb at N+1, m_ack at N+2, requester ack at N+3.
  - The next accept is possible at N+3, giving one transaction per 3 cycles.
- Data abort: if d_cyc drops while the data owner is in REQ or WAIT:
  - Drop m_stb immediately; m_cyc stays high until m_ack or timeout.
  - d_ack is suppressed; the write may already be committed.
  - Return to IDLE; bus_err is not set.
- m_ack outside WAIT is ignored.
- Reset mid-transaction: return to IDLE, no ack delivered to any requester, late m_ack ignored.
- Address is passed through unchanged. Memory word select (addr>>2) remains the memory's job.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum state_t {IDLE, REQ, WAIT}
  - typedef enum owner_t {OWN_FETCH, OWN_DATA}
  - localparam SEL_ALL = 4'hF
- Sub-module mem_arb_grant holds the grant decision and the starve_cnt counter (inputs: req_if, req_d, idle; output: grant).
- The top level holds the FSM, the transaction registers and the timeout timer.

Test Plan:
- Fetch only: if_stb=1, if_addr=0x010, memory word 4 = 0x00500093 -> if_stall=0 at N, m_stb at N+1, if_ack at N+3 with if_instr=0x00500093; d_ack stays 0.
- Data write: d_cyc=d_stb=d_wr_en=1, d_addr=0x024, d_wr_data=0xDEADBEEF, d_sel=4'b0011 -> m_sel=4'b0011, m_wr_en=1, d_ack at N+3; a read of 0x024 then returns low half 0xBEEF.
- Starvation (STARVE_LIMIT=4): both requesting continuously -> grant sequence D,D,D,D,F,D,D,D,D,F; every fetch ack arrives within 15 cycles of the previous one.
- Memory stall: m_stall=1 for 3 cycles during REQ -> m_stb stays high 4 cycles, ack delayed 3 cycles, other requester's stall held high throughout.
- Timeout (TIMEOUT=16): m_ack tied 0 -> owner ack 16 cycles after entering WAIT, read data 0, bus_err=1 and stays 1 until rst_n=0.
- Reset/abort: rst_n=0 in WAIT -> next cycle m_cyc=0, no ack, a later m_ack is ignored; separately, d_cyc dropped in WAIT -> m_stb=0, no d_ack, IDLE after m_ack, bus_err=0.
